retune_sequencer: RTL and testbench
===================================

Name: retune_sequencer

Overview:
- Controls DDS phase retuning for the multichannel downconverter: NCOs → mixers → CIC → width converter → FIR.
- Host writes per-channel phase increments into a shadow bank, then issues a commit.
- On commit, the block transfers shadows to the active bank, pulses the DDS phase-valid strobe, resets the conv/FIR chain, and gates output until the filters have flushed.

Parameters:
NUM_CHANS, 13, number of DDS/mixer channels
PHASE_WIDTH, 32, DDS phase-increment width
CHAN_BITS, 4, width of channel index (>= clog2(NUM_CHANS))
RST_CYCLES, 16, cycles dp_rstn held low per retune (>= 2)
SETTLE_CYCLES, 4096, cycles after dp_rstn release before out_gate rises (>= 1)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
wr_en  in  1  shadow write strobe
wr_chan  in  CHAN_BITS  shadow index
wr_phase  in  PHASE_WIDTH  phase increment to write
commit  in  1  single-cycle request to apply shadows
clear_err  in  1  clears err_sticky
phase_out  out  NUM_CHANS*PHASE_WIDTH  active phases; chan j at [j*PHASE_WIDTH +: PHASE_WIDTH]
phase_vld  out  1  one-cycle DDS phase load strobe
dp_rstn  out  1  active-low reset to conv/FIR chain
out_gate  out  1  high when downstream samples are valid
busy  out  1  high in any state other than IDLE
retune_cnt  out  16  completed retunes, wraps at 0xFFFF→0
err_sticky  out  1  latched protocol error

Behaviour:
- Reset (async assert, sync-released use on aclk): shadows and active bank 0, phase_vld 0, dp_rstn 0, out_gate 0, retune_cnt 0, err_sticky 0, pending 0. FSM enters RST.
- FSM states: IDLE, LOAD, RST, SETTLE.
  - IDLE → LOAD on commit or pending.
  - LOAD lasts 1 cycle: active bank ← shadows, phase_vld=1, pending cleared → RST.
  - RST: dp_rstn=0 for exactly RST_CYCLES cycles → SETTLE.
  - SETTLE: dp_rstn=1, count SETTLE_CYCLES cycles → IDLE.
  - IDLE entry: out_gate=1, and retune_cnt+1 only if the exit came via LOAD.
  - The post-reset RST/SETTLE pass does not count as a retune.
- out_gate is 0 in LOAD, RST and SETTLE, and 1 in IDLE. It falls in the cycle after commit is sampled; the first IDLE cycle has out_gate=1. All outputs are registered.
- Latency:
  - commit in IDLE at cycle N → phase_vld high in cycle N+1.
  - dp_rstn low in cycles N+2 .. N+1+RST_CYCLES.
  - out_gate high in cycle N+2+RST_CYCLES+SETTLE_CYCLES.
- Shadow writes are accepted in every state. A write during LOAD lands in the shadow only, after the copy. The active bank changes only in LOAD.
- wr_chan >= NUM_CHANS: write dropped, err_sticky set.
- commit while busy: pending set, err_sticky not set. Multiple commits while busy coalesce into one pending retune. Pending is serviced on the first IDLE cycle, so IDLE lasts 1 cycle with out_gate=1.
- commit in the same cycle as wr_en while IDLE: the write is included in the load, because the shadow write precedes the LOAD copy.
- clear_err and an error in the same cycle: err_sticky stays 1 (set wins).
- aresetn asserted mid-operation: everything returns to reset values immediately. A pending request is discarded.

Decomposition:
- Shared package holds: FSM state enum (IDLE, LOAD, RST, SETTLE); PHASE_WIDTH and NUM_CHANS defaults; a function computing counter width from max(RST_CYCLES, SETTLE_CYCLES).
- One natural sub-module: phase_bank. It holds the shadow and active register arrays, with a write port and a copy strobe.
- The FSM and counters stay in the top module.

Test Plan:
- Reset release, defaults → dp_rstn low 16 cycles, then out_gate rises 4096 cycles later; retune_cnt=0, phase_out=0.
- Write chan0=0x1000_0000, chan12=0xFFFF_FFFF, commit at cycle N → phase_vld only at N+1; phase_out slices match; out_gate high at N+4114; retune_cnt=1.
- Three commits during SETTLE → exactly one extra retune; retune_cnt=2; err_sticky=0.
- wr_chan=13 → no slice changes; err_sticky=1. clear_err together with another bad write → err_sticky remains 1; clear_err alone → 0.
- wr_en chan3=0xABCD in the same cycle as commit → chan3 active = 0xABCD after LOAD. Write during RST → active bank unchanged until the next commit.
- aresetn low during RST after a pending commit → all outputs at reset values; after release, no LOAD occurs (retune_cnt=0, phase_vld never pulses).

Source files
------------

// File: rtl/retune_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// retune_sequencer_pkg : shared defaults, FSM encoding, counter sizing
// Revision: 1.0
// ----------------------------------------------------------------------------
package retune_sequencer_pkg;

  localparam int c_num_chans   = 13;
  localparam int c_phase_width = 32;

  typedef logic [1:0] state_t;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_load   = 2'd1;
  localparam logic [1:0] c_st_rst    = 2'd2;
  localparam logic [1:0] c_st_settle = 2'd3;

  // The counter runs 0 .. max-1, so clog2(max) bits suffice.
  function automatic int cnt_width(input int rst_cycles, input int settle_cycles);
    int max_cycles;
    max_cycles = (rst_cycles > settle_cycles) ? rst_cycles : settle_cycles;
    return (max_cycles < 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage
`default_nettype wire

// File: rtl/retune_sequencer_phase_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// retune_sequencer_phase_bank : shadow/active phase-increment registers
// Revision: 1.0
// ----------------------------------------------------------------------------
module retune_sequencer_phase_bank
  import retune_sequencer_pkg::*;
#(
  parameter int NUM_CHANS   = c_num_chans,
  parameter int PHASE_WIDTH = c_phase_width,
  parameter int CHAN_BITS   = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             wr_en,
  input  logic [CHAN_BITS-1:0]             wr_chan,
  input  logic [PHASE_WIDTH-1:0]           wr_phase,
  input  logic                             copy,
  output logic [NUM_CHANS*PHASE_WIDTH-1:0] phase_out
);

  for (genvar j = 0; j < NUM_CHANS; j++) begin : g_chan
    logic [PHASE_WIDTH-1:0] r_shadow;
    logic [PHASE_WIDTH-1:0] r_active;
    logic                   w_hit;

    assign w_hit = wr_en && (wr_chan == CHAN_BITS'(j));

    // A write coinciding with the copy is forwarded so it joins this load.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_shadow <= '0;
        r_active <= '0;
      end else begin
        if (w_hit) r_shadow <= wr_phase;
        if (copy)  r_active <= w_hit ? wr_phase : r_shadow;
      end
    end

    assign phase_out[j*PHASE_WIDTH +: PHASE_WIDTH] = r_active;
  end

endmodule
`default_nettype wire

// File: rtl/retune_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// retune_sequencer : commit shadows, strobe DDS, reset conv/FIR, gate output
// Revision: 1.0
// ----------------------------------------------------------------------------
module retune_sequencer
  import retune_sequencer_pkg::*;
#(
  parameter int NUM_CHANS     = c_num_chans,
  parameter int PHASE_WIDTH   = c_phase_width,
  parameter int CHAN_BITS     = 4,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 4096
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             wr_en,
  input  logic [CHAN_BITS-1:0]             wr_chan,
  input  logic [PHASE_WIDTH-1:0]           wr_phase,
  input  logic                             commit,
  input  logic                             clear_err,
  output logic [NUM_CHANS*PHASE_WIDTH-1:0] phase_out,
  output logic                             phase_vld,
  output logic                             dp_rstn,
  output logic                             out_gate,
  output logic                             busy,
  output logic [15:0]                      retune_cnt,
  output logic                             err_sticky
);

  localparam int                 c_cnt_w       = cnt_width(RST_CYCLES, SETTLE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_rst_last    = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
  localparam logic [CHAN_BITS:0] c_chan_limit  = (CHAN_BITS+1)'(NUM_CHANS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               r_pending;
  logic               r_via_load;
  logic               w_chan_ok;
  logic               w_wr_ok;
  logic               w_bad_wr;
  logic               w_go;

  assign w_chan_ok = ({1'b0, wr_chan} < c_chan_limit);
  assign w_wr_ok   = wr_en &  w_chan_ok;
  assign w_bad_wr  = wr_en & ~w_chan_ok;
  assign w_go      = (r_state == c_st_idle) & (commit | r_pending);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_st_idle: if (w_go) w_state_nxt = c_st_load;
      c_st_load: begin
        w_state_nxt = c_st_rst;
        w_cnt_nxt   = '0;
      end
      c_st_rst: begin
        if (r_cnt == c_rst_last) begin
          w_state_nxt = c_st_settle;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      c_st_settle: begin
        if (r_cnt == c_settle_last) begin
          w_state_nxt = c_st_idle;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= c_st_rst;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_via_load <= 1'b0;
      phase_vld  <= 1'b0;
      dp_rstn    <= 1'b0;
      out_gate   <= 1'b0;
      busy       <= 1'b1;
      retune_cnt <= '0;
      err_sticky <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      phase_vld <= (w_state_nxt == c_st_load);
      dp_rstn   <= (w_state_nxt != c_st_rst);
      out_gate  <= (w_state_nxt == c_st_idle);
      busy      <= (w_state_nxt != c_st_idle);

      if (w_go)                                r_pending <= 1'b0;
      else if (commit && r_state != c_st_idle) r_pending <= 1'b1;

      if (w_go) r_via_load <= 1'b1;

      if (r_state == c_st_settle && w_state_nxt == c_st_idle && r_via_load)
        retune_cnt <= retune_cnt + 16'd1;

      if (w_bad_wr)       err_sticky <= 1'b1;
      else if (clear_err) err_sticky <= 1'b0;
    end
  end

  retune_sequencer_phase_bank #(
    .NUM_CHANS   (NUM_CHANS),
    .PHASE_WIDTH (PHASE_WIDTH),
    .CHAN_BITS   (CHAN_BITS)
  ) u_phase_bank (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .wr_en     (w_wr_ok),
    .wr_chan   (wr_chan),
    .wr_phase  (wr_phase),
    .copy      (w_go),
    .phase_out (phase_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_retune_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_retune_sequencer : scoreboard bench for retune_sequencer
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_retune_sequencer;

  localparam int NUM_CHANS     = 13;
  localparam int PHASE_WIDTH   = 32;
  localparam int CHAN_BITS     = 4;
  localparam int RST_CYCLES    = 16;
  localparam int SETTLE_CYCLES = 4096;
  localparam int PASS          = 2 + RST_CYCLES + SETTLE_CYCLES;
  localparam int BW            = NUM_CHANS * PHASE_WIDTH;

  logic                 aclk;
  logic                 aresetn;
  logic                 wr_en;
  logic [CHAN_BITS-1:0] wr_chan;
  logic [31:0]          wr_phase;
  logic                 commit;
  logic                 clear_err;
  logic [BW-1:0]        phase_out;
  logic                 phase_vld;
  logic                 dp_rstn;
  logic                 out_gate;
  logic                 busy;
  logic [15:0]          retune_cnt;
  logic                 err_sticky;

  typedef struct {
    int            cyc;
    logic [BW-1:0] phases;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [31:0]   m_shadow[NUM_CHANS];
  logic [BW-1:0] m_active;
  logic [15:0]   m_cnt;
  int            cyc;
  int            n_checks;
  int            n_fail;

  retune_sequencer #(
    .NUM_CHANS     (NUM_CHANS),
    .PHASE_WIDTH   (PHASE_WIDTH),
    .CHAN_BITS     (CHAN_BITS),
    .RST_CYCLES    (RST_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .wr_en      (wr_en),
    .wr_chan    (wr_chan),
    .wr_phase   (wr_phase),
    .commit     (commit),
    .clear_err  (clear_err),
    .phase_out  (phase_out),
    .phase_vld  (phase_vld),
    .dp_rstn    (dp_rstn),
    .out_gate   (out_gate),
    .busy       (busy),
    .retune_cnt (retune_cnt),
    .err_sticky (err_sticky)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1);
  end

  // Every phase_vld pulse must match the oldest expected load.
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && phase_vld === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_phase_vld: pulse at cycle %0d, required none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if (cyc !== mon_e.cyc) begin
          n_fail++;
          $display("FAIL load_cycle: got cycle %0d, expected %0d", cyc, mon_e.cyc);
        end
        if (phase_out !== mon_e.phases) begin
          n_fail++;
          $display("FAIL load_phases: got %h, expected %h", phase_out, mon_e.phases);
        end
      end
    end
  end

  function automatic logic [BW-1:0] pack_shadow();
    logic [BW-1:0] v;
    for (int j = 0; j < NUM_CHANS; j++) v[j*PHASE_WIDTH +: PHASE_WIDTH] = m_shadow[j];
    return v;
  endfunction

  task automatic push_load(input int at_cyc);
    exp_q.push_back('{cyc: at_cyc, phases: pack_shadow()});
    m_active = pack_shadow();
  endtask

  task automatic drive_wr(input logic [CHAN_BITS-1:0] ch, input logic [31:0] ph,
                          input logic clr, input logic cmt);
    wr_en = 1'b1; wr_chan = ch; wr_phase = ph; clear_err = clr; commit = cmt;
    if (int'(ch) < NUM_CHANS) m_shadow[ch] = ph;
    @(negedge aclk);
    wr_en = 1'b0; clear_err = 1'b0; commit = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge aclk);
    commit = 1'b0;
  endtask

  // which: 0 = dp_rstn, 1 = out_gate; at_cyc = -1 when the bound expires.
  task automatic wait_high(input int which, input int bound, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge aclk);
      if (((which == 0) ? dp_rstn : out_gate) === 1'b1) begin
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int rel, at;
    aresetn = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_phase = '0; commit = 1'b0; clear_err = 1'b0;
    for (int j = 0; j < NUM_CHANS; j++) m_shadow[j] = '0;
    m_active = '0; m_cnt = '0;
    repeat (3) @(negedge aclk);
    n_checks++;
    if ({phase_vld, dp_rstn, out_gate, busy, err_sticky} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_ctrl: vld/rstn/gate/busy/err got %b, expected 00010",
               {phase_vld, dp_rstn, out_gate, busy, err_sticky});
    end
    n_checks++;
    if (retune_cnt !== 16'd0 || phase_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data: cnt %0d phase %h, expected 0 and 0", retune_cnt, phase_out);
    end
    aresetn = 1'b1;
    rel = cyc;
    wait_high(0, RST_CYCLES + 4, at);
    n_checks++;
    if (at != rel + RST_CYCLES) begin
      n_fail++;
      $display("FAIL reset_dp_rstn_rise: got cycle %0d, expected %0d", at, rel + RST_CYCLES);
    end
    wait_high(1, SETTLE_CYCLES + 4, at);
    n_checks++;
    if (at != rel + RST_CYCLES + SETTLE_CYCLES) begin
      n_fail++;
      $display("FAIL reset_gate_rise: got cycle %0d, expected %0d", at, rel + RST_CYCLES + SETTLE_CYCLES);
    end
    n_checks++;
    if (retune_cnt !== 16'd0 || phase_out !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pass_idle: cnt %0d busy %b phase %h, expected 0 0 0", retune_cnt, busy, phase_out);
    end
  endtask

  task automatic test_commit();
    int n, at;
    drive_wr(4'd0,  32'h1000_0000, 1'b0, 1'b0);
    drive_wr(4'd12, 32'hFFFF_FFFF, 1'b0, 1'b0);
    n = cyc;
    push_load(n + 1);
    pulse_commit();
    n_checks++;
    if ({out_gate, busy, dp_rstn} !== 3'b011) begin
      n_fail++;
      $display("FAIL commit_load_cycle: gate/busy/rstn got %b, expected 011", {out_gate, busy, dp_rstn});
    end
    @(negedge aclk);
    n_checks++;
    if (dp_rstn !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_rstn_low: got %b at cycle %0d, expected 0", dp_rstn, cyc);
    end
    wait_high(0, RST_CYCLES + 4, at);
    n_checks++;
    if (at != n + 2 + RST_CYCLES) begin
      n_fail++;
      $display("FAIL commit_rstn_rise: got cycle %0d, expected %0d", at, n + 2 + RST_CYCLES);
    end
    wait_high(1, SETTLE_CYCLES + 4, at);
    n_checks++;
    if (at != n + PASS) begin
      n_fail++;
      $display("FAIL commit_gate_rise: got cycle %0d, expected %0d", at, n + PASS);
    end
    m_cnt = m_cnt + 16'd1;
    n_checks++;
    if (retune_cnt !== m_cnt || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_count: cnt %0d busy %b, expected %0d 0", retune_cnt, busy, m_cnt);
    end
    n_checks++;
    if (phase_out[0 +: 32] !== 32'h1000_0000 || phase_out[12*32 +: 32] !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL commit_slices: chan0 %h chan12 %h, expected 10000000 ffffffff",
               phase_out[0 +: 32], phase_out[12*32 +: 32]);
    end
  endtask

  task automatic test_back_to_back();
    int n, at, idle_at;
    n = cyc;
    push_load(n + 1);
    pulse_commit();
    idle_at = n + PASS;
    wait_high(0, RST_CYCLES + 4, at);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) push_load(idle_at + 1);
      pulse_commit();
      repeat (4) @(negedge aclk);
    end
    wait_high(1, SETTLE_CYCLES + 4, at);
    n_checks++;
    if (at != idle_at || retune_cnt !== m_cnt + 16'd1) begin
      n_fail++;
      $display("FAIL b2b_first_idle: cycle %0d cnt %0d, expected %0d %0d", at, retune_cnt, idle_at, m_cnt + 16'd1);
    end
    @(negedge aclk);
    n_checks++;
    if (out_gate !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle_one_cycle: gate %b busy %b, expected 0 1", out_gate, busy);
    end
    wait_high(1, PASS + 4, at);
    n_checks++;
    if (at != idle_at + PASS) begin
      n_fail++;
      $display("FAIL b2b_second_idle: got cycle %0d, expected %0d", at, idle_at + PASS);
    end
    m_cnt = m_cnt + 16'd2;
    n_checks++;
    if (retune_cnt !== m_cnt || err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count_err: cnt %0d err %b, expected %0d 0", retune_cnt, err_sticky, m_cnt);
    end
  endtask

  task automatic test_errors();
    drive_wr(4'd13, 32'hDEAD_BEEF, 1'b0, 1'b0);
    n_checks++;
    if (err_sticky !== 1'b1 || phase_out !== m_active) begin
      n_fail++;
      $display("FAIL err_bad_chan: err %b phase %h, expected 1 %h", err_sticky, phase_out, m_active);
    end
    drive_wr(4'd15, 32'h1234_5678, 1'b1, 1'b0);
    n_checks++;
    if (err_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set_wins: got %b, expected 1", err_sticky);
    end
    clear_err = 1'b1;
    @(negedge aclk);
    clear_err = 1'b0;
    n_checks++;
    if (err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b, expected 0", err_sticky);
    end
  endtask

  task automatic test_same_cycle_write();
    int n, at;
    n = cyc;
    m_shadow[3] = 32'h0000_ABCD;
    push_load(n + 1);
    drive_wr(4'd3, 32'h0000_ABCD, 1'b0, 1'b1);
    @(negedge aclk);
    drive_wr(4'd5, 32'h5555_0005, 1'b0, 1'b0);
    n_checks++;
    if (phase_out[3*32 +: 32] !== 32'h0000_ABCD || phase_out[5*32 +: 32] !== m_active[5*32 +: 32]) begin
      n_fail++;
      $display("FAIL rst_write_isolated: chan3 %h chan5 %h, expected 0000abcd %h",
               phase_out[3*32 +: 32], phase_out[5*32 +: 32], m_active[5*32 +: 32]);
    end
    wait_high(1, PASS + 4, at);
    m_cnt = m_cnt + 16'd1;
    n_checks++;
    if (at != n + PASS || retune_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL same_cycle_pass: cycle %0d cnt %0d, expected %0d %0d", at, retune_cnt, n + PASS, m_cnt);
    end
    n = cyc;
    push_load(n + 1);
    pulse_commit();
    wait_high(1, PASS + 4, at);
    m_cnt = m_cnt + 16'd1;
    n_checks++;
    if (phase_out[5*32 +: 32] !== 32'h5555_0005 || retune_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL next_commit_applies: chan5 %h cnt %0d, expected 55550005 %0d",
               phase_out[5*32 +: 32], retune_cnt, m_cnt);
    end
  endtask

  task automatic test_reset_midop();
    int n, rel, at;
    drive_wr(4'd14, 32'h0, 1'b0, 1'b0);
    n = cyc;
    push_load(n + 1);
    pulse_commit();
    @(negedge aclk);
    pulse_commit();
    aresetn = 1'b0;
    #1;
    for (int j = 0; j < NUM_CHANS; j++) m_shadow[j] = '0;
    m_active = '0; m_cnt = '0;
    n_checks++;
    if ({phase_vld, dp_rstn, out_gate, busy, err_sticky} !== 5'b00010 ||
        retune_cnt !== 16'd0 || phase_out !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: vld/rstn/gate/busy/err %b cnt %0d phase %h, expected 00010 0 0",
               {phase_vld, dp_rstn, out_gate, busy, err_sticky}, retune_cnt, phase_out);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    rel = cyc;
    wait_high(1, RST_CYCLES + SETTLE_CYCLES + 8, at);
    n_checks++;
    if (at != rel + RST_CYCLES + SETTLE_CYCLES) begin
      n_fail++;
      $display("FAIL midop_gate_rise: got cycle %0d, expected %0d", at, rel + RST_CYCLES + SETTLE_CYCLES);
    end
    repeat (5) @(negedge aclk);
    n_checks++;
    if (retune_cnt !== m_cnt || out_gate !== 1'b1 || phase_out !== m_active) begin
      n_fail++;
      $display("FAIL midop_pending_dropped: cnt %0d gate %b phase %h, expected 0 1 0",
               retune_cnt, out_gate, phase_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_commit();
    test_back_to_back();
    test_errors();
    test_same_cycle_write();
    test_reset_midop();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL loads_outstanding: got %0d unserviced, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
